config_loader: RTL and testbench

//  Writer side of the tile configuration interface. Accepts a byte-wide bitstream

---
 rtl/config_loader.sv | 156 +++++++++++++++
 tb/tb_config_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Writer side of the tile configuration interface: assembles byte-wide bitstream frames,
// strobes them one-hot into tiles and verifies header, count, pad bits and XOR checksum.
module config_loader #(
  parameter int unsigned NUM_TILES   = 4,
  parameter int unsigned FRAME_BITS  = 77,
  parameter int unsigned FRAME_BYTES = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [FRAME_BITS-1:0] bits_o,
  output logic [NUM_TILES-1:0]  wr_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned ShiftW = 8 * FRAME_BYTES;
  localparam logic [ShiftW-1:0] One = {{(ShiftW-1){1'b0}}, 1'b1};
  // Ones over the real config bits; everything above is pad and must be zero.
  localparam logic [ShiftW-1:0] FrameMask = (One << FRAME_BITS) - One;
  localparam logic [7:0] LastByte = 8'(FRAME_BYTES - 1);
  localparam logic [7:0] MaxCount = 8'(NUM_TILES);
  localparam logic [7:0] Header   = 8'hA5;

  typedef enum logic [2:0] {
    StIdle, StHdr, StCnt, StData, StWrite, StChk, StDone, StErr
  } state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, busy_q, done_q, err_q;
  logic [FRAME_BITS-1:0]   bits_q;
  logic [NUM_TILES-1:0]    wr_en_q;
  logic [ShiftW-9:0]       shift_q;
  logic [7:0]              byte_cnt_q;
  logic [7:0]              frame_idx_q;
  logic [7:0]              n_q;
  logic [7:0]              acc_q;

  logic                    xfer;
  logic                    last_byte;
  logic                    cnt_ok;
  logic                    pad_bad;
  logic [ShiftW-1:0]       frame_next;

  assign xfer       = byte_valid_i & ready_q;
  assign last_byte  = (byte_cnt_q == LastByte);
  assign cnt_ok     = (byte_i != 8'd0) && (byte_i <= MaxCount);
  assign frame_next = {shift_q, byte_i};
  assign pad_bad    = |(frame_next & ~FrameMask);

  assign byte_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign bits_o       = bits_q;
  assign wr_en_o      = wr_en_q;

  function automatic logic accepts_bytes(input state_e s);
    return (s == StHdr) || (s == StCnt) || (s == StData) || (s == StChk);
  endfunction

  function automatic logic is_busy(input state_e s);
    return (s == StHdr) || (s == StCnt) || (s == StData) || (s == StWrite) || (s == StChk);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) state_d = StHdr;
      end
      StHdr: begin
        if (xfer) state_d = (byte_i == Header) ? StCnt : StErr;
      end
      StCnt: begin
        if (xfer) state_d = cnt_ok ? StData : StErr;
      end
      StData: begin
        if (xfer && last_byte) state_d = pad_bad ? StErr : StWrite;
      end
      StWrite: begin
        state_d = ((frame_idx_q + 8'd1) < n_q) ? StData : StChk;
      end
      StChk: begin
        if (xfer) state_d = (byte_i == acc_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bits_q      <= '0;
      wr_en_q     <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= 8'd0;
      frame_idx_q <= 8'd0;
      n_q         <= 8'd0;
      acc_q       <= 8'd0;
    end else begin
      state_q <= state_d;
      ready_q <= accepts_bytes(state_d);
      busy_q  <= is_busy(state_d);
      wr_en_q <= '0;
      if (state_d == StErr && state_q != StErr) err_q <= 1'b1;
      if (state_d == StDone && state_q != StDone) done_q <= 1'b1;

      case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            shift_q     <= '0;
            byte_cnt_q  <= 8'd0;
            frame_idx_q <= 8'd0;
            n_q         <= 8'd0;
            acc_q       <= 8'd0;
          end
        end
        StCnt: begin
          if (xfer && cnt_ok) n_q <= byte_i;
        end
        StData: begin
          if (xfer) begin
            shift_q <= frame_next[ShiftW-9:0];
            acc_q   <= acc_q ^ byte_i;
            if (last_byte) begin
              byte_cnt_q <= 8'd0;
              // Strobe goes out together with the data so wr_en is high only in StWrite.
              if (!pad_bad) begin
                bits_q  <= frame_next[FRAME_BITS-1:0];
                wr_en_q <= NUM_TILES'(1) << frame_idx_q;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 8'd1;
            end
          end
        end
        StWrite: begin
          frame_idx_q <= frame_idx_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: framing, count, pad and checksum errors, reset mid-load.
module tb_config_loader;

  localparam int NT = 4;
  localparam int FB = 77;
  localparam int NB = 10;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [7:0]    byte_i = 8'd0;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic [FB-1:0] bits_o;
  logic [NT-1:0] wr_en_o;
  logic          busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;
  bit gaps_en = 1'b0;
  logic [7:0] acc_m;
  logic [NT-1:0] wr_log[$];
  logic [FB-1:0] bits_log[$];

  config_loader #(.NUM_TILES(NT), .FRAME_BITS(FB), .FRAME_BYTES(NB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .bits_o       (bits_o),
    .wr_en_o      (wr_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (wr_en_o != '0) begin
      wr_log.push_back(wr_en_o);
      bits_log.push_back(bits_o);
      check("wr_onehot", 128'($countones(wr_en_o)), 128'd1);
    end
  end

  // Byte 0 keeps bit 4 set (top valid config bit) and pad bits clear.
  function automatic logic [7:0] fb(input int f, input int j);
    if (j == 0) return 8'h10 | 8'(f);
    return 8'(f * 40 + j * 7 + 1);
  endfunction

  function automatic logic [FB-1:0] frame_exp(input int f);
    logic [8*NB-1:0] v = '0;
    for (int j = 0; j < NB; j++) v = {v[8*NB-9:0], fb(f, j)};
    return v[FB-1:0];
  endfunction

  task automatic send(input logic [7:0] b);
    int n = 0;
    int gap = gaps_en ? int'($urandom_range(0, 2)) : 0;
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk_i);
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!byte_ready_o) begin
      check("ready_timeout", 128'd0, 128'd1);
      byte_valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
      #1 byte_valid_i = 1'b0;
    end
  endtask

  task automatic send_frame(input int f, input bit corrupt_pad);
    logic [7:0] b;
    for (int j = 0; j < NB; j++) begin
      b = fb(f, j);
      if (j == 0 && corrupt_pad) b = b | 8'h20;
      acc_m = acc_m ^ b;
      send(b);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    acc_m = 8'd0;
    wr_log.delete();
    bits_log.delete();
  endtask

  task automatic check_writes(input string tag, input int n);
    logic [NT-1:0] one = 1;
    check({tag, "_nwr"}, 128'(wr_log.size()), 128'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      check({tag, "_wr"}, 128'(wr_log[i]), 128'(one << i));
      check({tag, "_bits"}, 128'(bits_log[i]), 128'(frame_exp(i)));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 128'(byte_ready_o), 128'd0);
    check("rst_bits", 128'(bits_o), 128'd0);
    check("rst_wr", 128'(wr_en_o), 128'd0);
    check("rst_flags", 128'({busy_o, done_o, err_o}), 128'd0);
    @(negedge clk_i) rst_i = 1'b0;

    // Full load of four tiles
    pulse_start();
    check("t1_busy", 128'({busy_o, byte_ready_o}), 128'b11);
    send(8'hA5);
    send(8'h04);
    send_frame(0, 1'b0);
    check("t1_wr_k1", 128'(wr_en_o), 128'b0001);
    check("t1_bits_k1", 128'(bits_o), 128'(frame_exp(0)));
    check("t1_ready_wr", 128'(byte_ready_o), 128'd0);
    @(posedge clk_i);
    #1;
    check("t1_wr_k2", 128'(wr_en_o), 128'd0);
    check("t1_ready_k2", 128'(byte_ready_o), 128'd1);
    for (int f = 1; f < 4; f++) send_frame(f, 1'b0);
    send(acc_m);
    check("t1_flags", 128'({busy_o, done_o, err_o, byte_ready_o}), 128'b0100);
    check_writes("t1", 4);
    check("t1_bits_hold", 128'(bits_o), 128'(frame_exp(3)));

    // Bad header
    pulse_start();
    send(8'h5A);
    check("t2_flags", 128'({busy_o, done_o, err_o, byte_ready_o}), 128'b0010);
    check_writes("t2", 0);

    // Count out of range, then a short load
    pulse_start();
    send(8'hA5);
    send(8'h00);
    check("t3_cnt0", 128'({done_o, err_o}), 128'b01);
    pulse_start();
    check("t3_clr", 128'({done_o, err_o}), 128'b00);
    send(8'hA5);
    send(8'h05);
    check("t3_cnt5", 128'({done_o, err_o}), 128'b01);
    pulse_start();
    send(8'hA5);
    send(8'h02);
    send_frame(0, 1'b0);
    send_frame(1, 1'b0);
    send(acc_m);
    check("t3_cnt2", 128'({done_o, err_o}), 128'b10);
    check_writes("t3", 2);

    // Pad bit set in the second frame
    pulse_start();
    send(8'hA5);
    send(8'h02);
    send_frame(0, 1'b0);
    send_frame(1, 1'b1);
    check("t4_flags", 128'({busy_o, done_o, err_o}), 128'b001);
    repeat (2) @(posedge clk_i);
    #1;
    check_writes("t4", 1);

    // Bad checksum: tiles written, error flagged, start clears it
    pulse_start();
    send(8'hA5);
    send(8'h04);
    for (int f = 0; f < 4; f++) send_frame(f, 1'b0);
    send(acc_m ^ 8'h01);
    check("t5_flags", 128'({done_o, err_o}), 128'b01);
    check_writes("t5", 4);
    pulse_start();
    check("t5_clr", 128'({err_o, busy_o}), 128'b01);

    // Gapped stream, reset in the middle of frame 2, then a clean reload
    gaps_en = 1'b1;
    send(8'hA5);
    send(8'h04);
    send_frame(0, 1'b0);
    send_frame(1, 1'b0);
    for (int j = 0; j < 4; j++) send(fb(2, j));
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("t6_rst_out", 128'({byte_ready_o, busy_o, done_o, err_o, wr_en_o}), 128'd0);
    check("t6_rst_bits", 128'(bits_o), 128'd0);
    check_writes("t6a", 2);
    @(negedge clk_i) rst_i = 1'b0;
    pulse_start();
    send(8'hA5);
    send(8'h04);
    for (int f = 0; f < 4; f++) begin
      send_frame(f, 1'b0);
      @(negedge clk_i) start_i = 1'b1;
      @(negedge clk_i) start_i = 1'b0;
    end
    send(acc_m);
    check("t6_flags", 128'({busy_o, done_o, err_o}), 128'b010);
    check_writes("t6b", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
